// File: rtl/alu_arbiter_if.sv
// Request/response/ALU bundle for alu_arbiter. The master side is the issue
// logic plus the ALU instance; the slave side is the arbiter.
interface alu_arbiter_if #(
    parameter int REGF_WIDTH = 32,
    parameter int OP_code    = 5
);
    logic                  req0_valid, req1_valid;
    logic                  req0_ready, req1_ready;
    logic [OP_code-1:0]    req0_op, req1_op;
    logic [REGF_WIDTH-1:0] req0_src1, req1_src1;
    logic [REGF_WIDTH-1:0] req0_src2, req1_src2;

    logic                  rsp0_valid, rsp1_valid;
    logic                  rsp0_ready, rsp1_ready;
    logic [REGF_WIDTH-1:0] rsp0_result, rsp1_result;
    logic [3:0]            rsp0_flags, rsp1_flags;

    logic [OP_code-1:0]    alu_op_code;
    logic [REGF_WIDTH-1:0] alu_source1, alu_source2;
    logic [REGF_WIDTH-1:0] alu_out_put;
    logic                  alu_zero, alu_overflow, alu_neg, alu_carry;

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op,
               req0_src1, req1_src1, req0_src2, req1_src2,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp0_result, rsp1_result,
               rsp0_flags, rsp1_flags,
        output rsp0_ready, rsp1_ready,
        input  alu_op_code, alu_source1, alu_source2,
        output alu_out_put, alu_zero, alu_overflow, alu_neg, alu_carry
    );

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op,
               req0_src1, req1_src1, req0_src2, req1_src2,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp0_result, rsp1_result,
               rsp0_flags, rsp1_flags,
        input  rsp0_ready, rsp1_ready,
        output alu_op_code, alu_source1, alu_source2,
        input  alu_out_put, alu_zero, alu_overflow, alu_neg, alu_carry
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters,
// with a one-deep response register per requester. Optional ALU_ARB_STATS_EN adds grant/conflict counters.
module alu_arbiter #(
    parameter int                 REGF_WIDTH = 32,
    parameter int                 OP_code    = 5,
    parameter logic [OP_code-1:0] NOP_CODE   = 5'b11111
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]  grant_cnt0,
    output logic [15:0]  grant_cnt1,
    output logic [15:0]  conflict_cnt
`endif
);
    localparam int NUM_REQ = 2;

    typedef struct packed {
        logic [OP_code-1:0]    op;
        logic [REGF_WIDTH-1:0] src1;
        logic [REGF_WIDTH-1:0] src2;
    } req_t;

    typedef struct packed {
        logic [REGF_WIDTH-1:0] result;
        logic [3:0]            flags;   // {carry, neg, overflow, zero}
    } rsp_t;

    req_t [NUM_REQ-1:0] req;
    rsp_t [NUM_REQ-1:0] rsp_q;
    rsp_t               alu_rsp;
    logic [NUM_REQ-1:0] req_valid, rsp_ready, rsp_valid, elig, grant;
    logic               prio;

    assign req[0]    = {bus.req0_op, bus.req0_src1, bus.req0_src2};
    assign req[1]    = {bus.req1_op, bus.req1_src1, bus.req1_src2};
    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
    assign alu_rsp   = {bus.alu_out_put, bus.alu_carry, bus.alu_neg, bus.alu_overflow, bus.alu_zero};

    // A slot being drained this cycle is free for a new result.
    assign elig = req_valid & (~rsp_valid | rsp_ready);

    always_comb begin
        grant = '0;
        if (!rst) begin
            if (&elig) grant[prio] = 1'b1;
            else       grant = elig;
        end
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];

    always_comb begin
        bus.alu_op_code = NOP_CODE;
        bus.alu_source1 = '0;
        bus.alu_source2 = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                bus.alu_op_code = req[i].op;
                bus.alu_source1 = req[i].src1;
                bus.alu_source2 = req[i].src2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           prio <= 1'b0;
        else if (grant[0]) prio <= 1'b1;
        else if (grant[1]) prio <= 1'b0;
    end

    // Grant wins over drain so a slot can turn over every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_q     <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    rsp_valid[i] <= 1'b1;
                    rsp_q[i]     <= alu_rsp;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.rsp0_valid  = rsp_valid[0];
    assign bus.rsp1_valid  = rsp_valid[1];
    assign bus.rsp0_result = rsp_q[0].result;
    assign bus.rsp1_result = rsp_q[1].result;
    assign bus.rsp0_flags  = rsp_q[0].flags;
    assign bus.rsp1_flags  = rsp_q[1].flags;

`ifdef ALU_ARB_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic en);
        return (en && cnt != 16'hFFFF) ? cnt + 16'd1 : cnt;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt0   <= '0;
            grant_cnt1   <= '0;
            conflict_cnt <= '0;
        end else begin
            grant_cnt0   <= sat_inc(grant_cnt0, grant[0]);
            grant_cnt1   <= sat_inc(grant_cnt1, grant[1]);
            conflict_cnt <= sat_inc(conflict_cnt, &elig);
        end
    end
`endif
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: requester 0 is the EX-stage integer path, requester 1 is an auxiliary unit such as the branch compare or address generation.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Requests are granted round-robin, one per cycle. The ALU result and flags are captured into a per-requester response register, so the response arrives one cycle after acceptance.
- Sits between the pipeline issue logic and the ALU instance.

Parameters:
- REGF_WIDTH, 32, datapath width of the operands and the result.
- OP_code, 5, width of the ALU op code.
- NOP_CODE, 5'b11111, op code driven to the ALU when no requester is granted.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req0_valid, req1_valid  input  1  request present.
- req0_ready, req1_ready  output  1  request accepted this cycle (the grant).
- req0_op, req1_op  input  OP_code  ALU op code.
- req0_src1, req1_src1  input  REGF_WIDTH  operand 1.
- req0_src2, req1_src2  input  REGF_WIDTH  operand 2.
- rsp0_valid, rsp1_valid  output  1  response register holds data.
- rsp0_ready, rsp1_ready  input  1  consumer takes the response.
- rsp0_result, rsp1_result  output  REGF_WIDTH  captured ALU result.
- rsp0_flags, rsp1_flags  output  4  captured flags, ordered {carry, neg, overflow, zero}.
- alu_op_code  output  OP_code  to the ALU.
- alu_source1, alu_source2  output  REGF_WIDTH  to the ALU.
- alu_out_put  input  REGF_WIDTH  from the ALU.
- alu_zero, alu_overflow, alu_neg, alu_carry  input  1  ALU flags.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - rsp*_valid = 0, rsp*_result = 0, rsp*_flags = 0.
  - The priority pointer prio = 0 (requester 0 wins the first tie).
  - req*_ready = 0 while rst is high.
- Eligibility: requester i is eligible when req_i_valid && (!rsp_i_valid || rsp_i_ready). A slot being drained in the same cycle counts as free.
- Grant (combinational, at most one per cycle):
  - Both eligible: grant the requester indicated by prio.
  - Exactly one eligible: grant that requester.
  - req_i_ready = grant_i.
- ALU drive:
  - When granted, the ALU receives the granted requester's op and operands.
  - When nothing is granted: alu_op_code = NOP_CODE, alu_source1 = 0, alu_source2 = 0.
- Priority update: on any grant to requester i, prio <= ~i on the next edge. With no grant, prio holds.
- Response register i, per clock edge:
  - If grant_i: rsp_i_valid <= 1, rsp_i_result <= alu_out_put, rsp_i_flags <= {alu_carry, alu_neg, alu_overflow, alu_zero}.
  - Else if rsp_i_valid && rsp_i_ready: rsp_i_valid <= 0. Result and flags hold their last value.
  - Simultaneous drain and grant: new data is loaded and valid stays 1, giving back-to-back throughput of 1 op per cycle per requester.
- Latency: accept in cycle N, rsp valid in cycle N+1.
- Response stability: while rsp_i_valid && !rsp_i_ready, result and flags are held stable.
- Backpressure isolation: a stalled response on one side never blocks grants to the other side.
- Fairness: a continuously eligible requester is granted within 2 cycles.
- Request signals may change freely while ready is low; only values present in the grant cycle are used.
- Reset mid-operation: accepted-but-undelivered responses are discarded, and prio returns to 0.
- The ALU is treated as purely combinational. No op-code decode happens here; codes pass through unchanged.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- When defined, adds three outputs:
  - grant_cnt0  16  grants to requester 0.
  - grant_cnt1  16  grants to requester 1.
  - conflict_cnt  16  cycles in which both requesters were eligible.
- All three counters reset to 0 and saturate at 16'hFFFF.
- When undefined, these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Single ADD: after reset, req0 op=5'b00010, src1=5, src2=7, valid for 1 cycle → req0_ready=1 that cycle. Next cycle rsp0_valid=1, rsp0_result=12, rsp0_flags=4'b0000.
- Tie and round-robin: req0 and req1 both valid with SUB (5'b00110) 3-3, responses always ready.
  - Cycle 0: grant to requester 0.
  - Cycle 1: grant to requester 1.
  - Both results are 0 with flags 4'b1001 (carry=1, zero=1).
  - Steady state alternates 0,1,0,1.
- Backpressure: rsp0_ready=0 with rsp0_valid=1 and req0 still valid → req0_ready stays 0 and rsp0_result is held. Meanwhile req1 (AND, 0xF0 & 0x3C) is granted every cycle and returns 0x30. Raising rsp0_ready re-grants req0 in that same cycle.
- Overflow: req1 ADD 0x7FFFFFFF + 1 → rsp1_result = 0x80000000, rsp1_flags = 4'b0110.
- Idle drive: no requests valid → alu_op_code = 5'b11111, alu_source1/2 = 0, prio unchanged.
- Reset mid-operation: assert rst asynchronously with rsp0_valid=1 and rsp0_ready=0 → rsp0_valid drops to 0 immediately. After release, a tie is granted to requester 0. With ALU_ARB_STATS_EN defined, all counters read 0.
